// File: rtl/snax_csr_arbiter.sv
// rtl/snax_csr_arbiter.sv - round-robin CSR port arbiter with in-order read response routing
module snax_csr_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned IdWidth     = 5,
  parameter int unsigned MaxOutstand = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq*32-1:0]        req_data_i,
  input  logic [NumReq*32-1:0]        req_addr_i,
  input  logic [NumReq-1:0]           req_write_i,
  input  logic [NumReq*IdWidth-1:0]   req_id_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic [31:0]                 rsp_data_o,
  output logic [IdWidth-1:0]          rsp_id_o,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [31:0]                 csr_req_bits_data_o,
  output logic [31:0]                 csr_req_bits_addr_o,
  output logic                        csr_req_bits_write_o,
  output logic                        csr_req_valid_o,
  input  logic                        csr_req_ready_i,
  input  logic                        csr_rsp_valid_i,
  output logic                        csr_rsp_ready_o,
  input  logic [31:0]                 csr_rsp_bits_data_i,
  output logic                        err_o
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(MaxOutstand);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstand);

  logic [IdxW-1:0]    rr_q, lock_idx_q, grant_idx, head_idx;
  logic               lock_q, err_q;
  logic [CntW-1:0]    count_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0]    fifo_idx_q [MaxOutstand];
  logic [IdWidth-1:0] fifo_id_q  [MaxOutstand];
  logic [NumReq-1:0]  eligible;
  logic               fifo_full, fifo_empty, req_hs, push, pop, stray;
  int                 cand;

  assign fifo_full  = (count_q == MaxCnt);
  assign fifo_empty = (count_q == '0);
  // A full tracking FIFO only stalls reads; writes never produce a response.
  assign eligible   = req_valid_i & (req_write_i | {NumReq{!fifo_full}});

  // Descending scan so the candidate closest to rr is the last one assigned.
  always_comb begin
    grant_idx = rr_q;
    cand      = 0;
    if (lock_q) begin
      grant_idx = lock_idx_q;
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        cand = (int'(rr_q) + i) % int'(NumReq);
        if (eligible[IdxW'(cand)]) grant_idx = IdxW'(cand);
      end
    end
  end

  assign csr_req_valid_o      = lock_q ? req_valid_i[lock_idx_q] : (|eligible);
  assign csr_req_bits_data_o  = req_data_i[32*int'(grant_idx) +: 32];
  assign csr_req_bits_addr_o  = req_addr_i[32*int'(grant_idx) +: 32];
  assign csr_req_bits_write_o = req_write_i[grant_idx];

  always_comb begin
    req_ready_o = '0;
    if (csr_req_valid_o) req_ready_o[grant_idx] = csr_req_ready_i;
  end

  assign req_hs = csr_req_valid_o && csr_req_ready_i;
  assign push   = req_hs && !csr_req_bits_write_o && !fifo_full;

  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign rsp_id_o = fifo_id_q[rd_ptr_q];
  assign rsp_data_o = csr_rsp_bits_data_i;

  always_comb begin
    rsp_valid_o = '0;
    if (!fifo_empty) rsp_valid_o[head_idx] = csr_rsp_valid_i;
  end

  // With nothing outstanding the response is swallowed and flagged.
  assign csr_rsp_ready_o = fifo_empty ? csr_rsp_valid_i : rsp_ready_i[head_idx];
  assign pop   = !fifo_empty && csr_rsp_valid_i && rsp_ready_i[head_idx];
  assign stray = fifo_empty && csr_rsp_valid_i;
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (req_hs) rr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
      lock_q <= csr_req_valid_o && !csr_req_ready_i;
      if (csr_req_valid_o) lock_idx_q <= grant_idx;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (stray) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= grant_idx;
      fifo_id_q[wr_ptr_q]  <= req_id_i[IdWidth*int'(grant_idx) +: IdWidth];
    end
  end

endmodule
